// File: rtl/uart_pkg.sv
// Shared types and helpers for the debug-link UART blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversampling);
        return clk_freq / (baud_rate * oversampling);
    endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// Free-running divider producing a one-clk tick every DIV cycles.
module baud_rate_gen #(
    parameter int unsigned DIV = 325
) (
    input  logic clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-FF synchronizer, mid-bit sampling FSM,
// registered done / framing-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned NB_DATA      = 8,
    parameter int unsigned NB_STOP      = 16,
    parameter int unsigned BAUD_RATE    = 19200,
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned OVERSAMPLING = 16
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxdone,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLING);
    localparam int unsigned TMAX  = (OVERSAMPLING > NB_STOP) ? OVERSAMPLING : NB_STOP;
    localparam int unsigned TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned BW    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLING - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(NB_STOP - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);

    logic               tick;
    logic               rx_meta, rx_s;
    rx_state_t          state, state_n;
    logic [TW-1:0]      tcnt, tcnt_n;
    logic [BW-1:0]      bitcnt, bitcnt_n;
    logic [NB_DATA-1:0] shift, shift_n;
    logic [NB_DATA-1:0] data_n;
    logic               rxdone_n, ferr_n;

    baud_rate_gen #(.DIV(DIV)) u_baud (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .o_tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            rx_meta     <= LINE_IDLE;
            rx_s        <= LINE_IDLE;
            state       <= IDLE;
            tcnt        <= '0;
            bitcnt      <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_rxdone    <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_meta     <= i_rx;
            rx_s        <= rx_meta;
            state       <= state_n;
            tcnt        <= tcnt_n;
            bitcnt      <= bitcnt_n;
            shift       <= shift_n;
            o_data      <= data_n;
            o_rxdone    <= rxdone_n;
            o_frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n  = state;
        tcnt_n   = tcnt;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        data_n   = o_data;
        rxdone_n = 1'b0;
        ferr_n   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_s != LINE_IDLE) begin
                    state_n = START;
                    tcnt_n  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tcnt == HALF_LAST) begin
                        // A start bit that is no longer low at its midpoint is a glitch.
                        if (rx_s != LINE_IDLE) begin
                            state_n  = DATA;
                            tcnt_n   = '0;
                            bitcnt_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tcnt == BIT_LAST) begin
                        shift_n = {rx_s, shift[NB_DATA-1:1]};
                        tcnt_n  = '0;
                        if (bitcnt == DATA_LAST) begin
                            state_n = STOP;
                        end else begin
                            bitcnt_n = bitcnt + 1'b1;
                        end
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tcnt == STOP_LAST) begin
                        if (rx_s == LINE_IDLE) begin
                            data_n   = shift;
                            rxdone_n = 1'b1;
                        end else begin
                            ferr_n = 1'b1;
                        end
                        state_n = IDLE;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced clock so one bit is 160 clk.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 3_072_000;
    localparam int unsigned BAUD     = 19200;
    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_rxdone, o_frame_err, o_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_done = 0, n_err = 0, n_both = 0, n_busy_cyc = 0;
    int last_done_cyc = 0;

    uart_rx #(
        .NB_DATA      (8),
        .NB_STOP      (16),
        .BAUD_RATE    (BAUD),
        .CLK_FREQ     (CLK_FREQ),
        .OVERSAMPLING (16)
    ) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rxdone    (o_rxdone),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_rxdone) begin
            n_done++;
            last_done_cyc = cyc;
        end
        if (o_frame_err) n_err++;
        if (o_rxdone && o_frame_err) n_both++;
        if (o_busy) n_busy_cyc++;
    end

    task automatic hold(input logic v, input int n);
        i_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int bitlen,
                              input logic stop_lvl, input int stop_len);
        hold(1'b0, bitlen);
        for (int i = 0; i < 8; i++) hold(d[i], bitlen);
        hold(stop_lvl, stop_len);
        i_rx = 1'b1;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        i_rx = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (o_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", o_data); end
        n_cmp++; if (o_rxdone !== 1'b0) begin n_bad++; $display("FAIL reset_rxdone: got %b want 0", o_rxdone); end
        n_cmp++; if (o_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        i_rst_n = 1'b1;
        hold(1'b1, 2 * BIT);
    endtask

    task automatic test_basic;
        int d0, e0, t0, lat;
        d0 = n_done; e0 = n_err; t0 = cyc;
        send_frame(8'hA5, BIT, 1'b1, BIT);
        hold(1'b1, BIT);
        lat = last_done_cyc - t0;
        n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL basic_done_cnt: got %0d want 1", n_done - d0); end
        n_cmp++; if (o_data !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %h want a5", o_data); end
        n_cmp++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL basic_ferr_cnt: got %0d want 0", n_err - e0); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b want 0", o_busy); end
        // 2 sync clk + (8 + 128 + 16) ticks of 10 clk, +/- one tick
        n_cmp++; if (lat < 1512 || lat > 1532) begin n_bad++; $display("FAIL basic_latency: got %0d want 1512..1532", lat); end
    endtask

    task automatic test_glitch;
        int d0, e0;
        d0 = n_done; e0 = n_err; n_busy_cyc = 0;
        hold(1'b0, 30);
        hold(1'b1, 2 * BIT);
        n_cmp++; if (n_busy_cyc == 0) begin n_bad++; $display("FAIL glitch_busy_seen: got %0d busy cycles want >0", n_busy_cyc); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_after: got %b want 0", o_busy); end
        n_cmp++; if (n_done - d0 !== 0) begin n_bad++; $display("FAIL glitch_done_cnt: got %0d want 0", n_done - d0); end
        n_cmp++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL glitch_ferr_cnt: got %0d want 0", n_err - e0); end
        n_cmp++; if (o_data !== 8'hA5) begin n_bad++; $display("FAIL glitch_data: got %h want a5", o_data); end
    endtask

    task automatic test_frame_err;
        int d0, e0;
        d0 = n_done; e0 = n_err;
        send_frame(8'h3C, BIT, 1'b0, BIT * 5 / 8);
        hold(1'b1, 2 * BIT);
        n_cmp++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL ferr_cnt: got %0d want 1", n_err - e0); end
        n_cmp++; if (n_done - d0 !== 0) begin n_bad++; $display("FAIL ferr_done_cnt: got %0d want 0", n_done - d0); end
        n_cmp++; if (o_data !== 8'hA5) begin n_bad++; $display("FAIL ferr_data: got %h want a5", o_data); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy_after: got %b want 0", o_busy); end
    endtask

    task automatic test_back_to_back;
        int d0, t1, dt;
        d0 = n_done;
        send_frame(8'h00, BIT, 1'b1, BIT);
        t1 = last_done_cyc;
        n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL b2b_first_cnt: got %0d want 1", n_done - d0); end
        n_cmp++; if (o_data !== 8'h00) begin n_bad++; $display("FAIL b2b_first_data: got %h want 00", o_data); end
        send_frame(8'hFF, BIT, 1'b1, BIT);
        hold(1'b1, BIT);
        dt = last_done_cyc - t1;
        n_cmp++; if (n_done - d0 !== 2) begin n_bad++; $display("FAIL b2b_second_cnt: got %0d want 2", n_done - d0); end
        n_cmp++; if (o_data !== 8'hFF) begin n_bad++; $display("FAIL b2b_second_data: got %h want ff", o_data); end
        n_cmp++; if (dt < 1590 || dt > 1610) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 1590..1610", dt); end
    endtask

    task automatic test_reset_midframe;
        int d0, e0;
        d0 = n_done; e0 = n_err;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(1'b1 ^ (i == 3), BIT);
        hold(1'b1, BIT / 2);
        i_rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", o_data); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_rxdone !== 1'b0 || o_frame_err !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_strobes: got %b%b want 00", o_rxdone, o_frame_err);
        end
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        hold(1'b1, 2 * BIT);
        n_cmp++; if (n_done - d0 !== 0 || n_err - e0 !== 0) begin
            n_bad++; $display("FAIL rstmid_aborted: got done %0d err %0d want 0 0", n_done - d0, n_err - e0);
        end
        send_frame(8'h5A, BIT, 1'b1, BIT);
        hold(1'b1, BIT);
        n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL rstmid_next_cnt: got %0d want 1", n_done - d0); end
        n_cmp++; if (o_data !== 8'h5A) begin n_bad++; $display("FAIL rstmid_next_data: got %h want 5a", o_data); end
    endtask

    task automatic test_baud_skew;
        int d0, e0;
        d0 = n_done; e0 = n_err;
        send_frame(8'hC3, BIT + 3, 1'b1, BIT + 3);
        hold(1'b1, BIT);
        n_cmp++; if (o_data !== 8'hC3) begin n_bad++; $display("FAIL skew_slow_data: got %h want c3", o_data); end
        n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL skew_slow_cnt: got %0d want 1", n_done - d0); end
        hold(1'b1, 2);
        send_frame(8'h00, BIT, 1'b1, BIT);
        hold(1'b1, BIT);
        send_frame(8'hC3, BIT - 3, 1'b1, BIT - 3);
        hold(1'b1, BIT);
        n_cmp++; if (o_data !== 8'hC3) begin n_bad++; $display("FAIL skew_fast_data: got %h want c3", o_data); end
        n_cmp++; if (n_done - d0 !== 3) begin n_bad++; $display("FAIL skew_fast_cnt: got %0d want 3", n_done - d0); end
        n_cmp++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL skew_ferr_cnt: got %0d want 0", n_err - e0); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_glitch;
        test_frame_err;
        test_back_to_back;
        test_reset_midframe;
        test_baud_skew;
        n_cmp++; if (n_both !== 0) begin n_bad++; $display("FAIL strobe_overlap: got %0d want 0", n_both); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
